// File: rtl/dcmac_0_axis_stat_snap_if.sv
// Register read port of the statistics snapshot stage.
// The master issues rd_en/rd_addr; the slave returns rd_vld/rd_data one cycle later.
interface dcmac_0_axis_stat_snap_if;
  logic        rd_en;
  logic [7:0]  rd_addr;
  logic        rd_vld;
  logic [31:0] rd_data;

  modport master (output rd_en, output rd_addr, input rd_vld, input rd_data);
  modport slave  (input rd_en, input rd_addr, output rd_vld, output rd_data);
endinterface

// File: rtl/dcmac_0_axis_stat_snap.sv
// Per-port statistics snapshot: latches monitor counters on request, keeps deltas and sticky lock-loss.
// Define DCMAC_0_STAT_SNAP_CLEAR_EN to add a CLEAR state that pulses the monitor counter clears.
module dcmac_0_axis_stat_snap #(
  parameter int NUM_PORTS = 6
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [NUM_PORTS-1:0][63:0] i_pkt_cnt,
  input  logic [NUM_PORTS-1:0][63:0] i_byte_cnt,
  input  logic [NUM_PORTS-1:0][31:0] i_prbs_err_cnt,
  input  logic [NUM_PORTS-1:0]       i_prbs_locked,
  input  logic [NUM_PORTS-1:0]       i_snap_req,
  output logic [NUM_PORTS-1:0]       o_clear_counters,
  output logic [NUM_PORTS-1:0]       o_snap_done,
  output logic                       o_busy,
  output logic [NUM_PORTS-1:0]       o_lock_lost,
  dcmac_0_axis_stat_snap_if.slave    rd
);

  localparam int PW = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_CAPTURE = 2'd1,
`ifdef DCMAC_0_STAT_SNAP_CLEAR_EN
    S_CLEAR   = 2'd2,
`endif
    S_DONE    = 2'd3
  } state_t;

  state_t               state_q;
  logic [PW-1:0]        cur_q;
  logic [PW-1:0]        last_q;
  logic [PW-1:0]        sel;
  logic [PW-1:0]        idx;
  logic                 sel_vld;
  logic [NUM_PORTS-1:0] pend_q;
  logic [NUM_PORTS-1:0] pend_nxt;
  logic [NUM_PORTS-1:0] enter_oh;
  logic [NUM_PORTS-1:0] cur_oh;
  logic [NUM_PORTS-1:0] cap_oh;
  logic [NUM_PORTS-1:0] locked_q;
  logic [NUM_PORTS-1:0] lock_fall;
  logic                 busy_nxt;

  logic [63:0]          pkt_sh    [NUM_PORTS];
  logic [63:0]          byte_sh   [NUM_PORTS];
  logic [31:0]          err_sh    [NUM_PORTS];
  logic [63:0]          dpkt_sh   [NUM_PORTS];
  logic [63:0]          dbyte_sh  [NUM_PORTS];
  logic [63:0]          prev_pkt  [NUM_PORTS];
  logic [63:0]          prev_byte [NUM_PORTS];
  logic [15:0]          snap_cnt  [NUM_PORTS];
  logic [NUM_PORTS-1:0] lock_sh;

  logic                 rd_port_ok;
  logic [PW-1:0]        rd_idx;
  logic [31:0]          rd_word;

  // Round-robin pick: the pending port nearest after the last-served one wins.
  always_comb begin
    sel     = last_q;
    sel_vld = 1'b0;
    idx     = '0;
    for (int k = NUM_PORTS; k >= 1; k--) begin
      idx = PW'((int'(last_q) + k) % NUM_PORTS);
      if (pend_q[idx]) begin
        sel     = idx;
        sel_vld = 1'b1;
      end
    end
  end

  assign cur_oh    = NUM_PORTS'(1) << cur_q;
  assign enter_oh  = (state_q == S_IDLE && sel_vld) ? (NUM_PORTS'(1) << sel) : '0;
  assign cap_oh    = (state_q == S_CAPTURE) ? cur_oh : '0;
  assign pend_nxt  = (pend_q & ~enter_oh) | i_snap_req;
  assign lock_fall = locked_q & ~i_prbs_locked;
  assign busy_nxt  = (|pend_nxt) || !(state_q == S_DONE || (state_q == S_IDLE && !sel_vld));

`ifdef DCMAC_0_STAT_SNAP_CLEAR_EN
  logic [NUM_PORTS-1:0] clr_q;
  assign o_clear_counters = clr_q;
`else
  assign o_clear_counters = '0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      cur_q       <= '0;
      last_q      <= PW'(NUM_PORTS - 1);
      pend_q      <= '0;
      locked_q    <= '0;
      lock_sh     <= '0;
      o_lock_lost <= '0;
      o_snap_done <= '0;
      o_busy      <= 1'b0;
`ifdef DCMAC_0_STAT_SNAP_CLEAR_EN
      clr_q       <= '0;
`endif
      for (int i = 0; i < NUM_PORTS; i++) begin
        pkt_sh[i]    <= '0;
        byte_sh[i]   <= '0;
        err_sh[i]    <= '0;
        dpkt_sh[i]   <= '0;
        dbyte_sh[i]  <= '0;
        prev_pkt[i]  <= '0;
        prev_byte[i] <= '0;
        snap_cnt[i]  <= '0;
      end
    end else begin
      o_snap_done <= '0;
`ifdef DCMAC_0_STAT_SNAP_CLEAR_EN
      clr_q       <= '0;
`endif
      pend_q      <= pend_nxt;
      locked_q    <= i_prbs_locked;
      // A falling edge in the capture cycle must survive the capture-time clear.
      o_lock_lost <= (o_lock_lost & ~cap_oh) | lock_fall;
      o_busy      <= busy_nxt;

      case (state_q)
        S_IDLE: begin
          if (sel_vld) begin
            state_q <= S_CAPTURE;
            cur_q   <= sel;
            last_q  <= sel;
          end
        end
        S_CAPTURE: begin
          pkt_sh[cur_q]    <= i_pkt_cnt[cur_q];
          byte_sh[cur_q]   <= i_byte_cnt[cur_q];
          err_sh[cur_q]    <= i_prbs_err_cnt[cur_q];
          lock_sh[cur_q]   <= i_prbs_locked[cur_q];
          dpkt_sh[cur_q]   <= i_pkt_cnt[cur_q] - prev_pkt[cur_q];
          dbyte_sh[cur_q]  <= i_byte_cnt[cur_q] - prev_byte[cur_q];
          prev_pkt[cur_q]  <= i_pkt_cnt[cur_q];
          prev_byte[cur_q] <= i_byte_cnt[cur_q];
          snap_cnt[cur_q]  <= snap_cnt[cur_q] + 16'd1;
`ifdef DCMAC_0_STAT_SNAP_CLEAR_EN
          state_q          <= S_CLEAR;
          clr_q            <= cur_oh;
`else
          state_q          <= S_DONE;
          o_snap_done      <= cur_oh;
`endif
        end
`ifdef DCMAC_0_STAT_SNAP_CLEAR_EN
        S_CLEAR: begin
          // The monitor restarts from zero, so the next delta is measured from zero.
          prev_pkt[cur_q]  <= '0;
          prev_byte[cur_q] <= '0;
          state_q          <= S_DONE;
          o_snap_done      <= cur_oh;
        end
`endif
        S_DONE: begin
          state_q <= S_IDLE;
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign rd_port_ok = (rd.rd_addr[7:4] < 4'(NUM_PORTS));
  assign rd_idx     = rd.rd_addr[4 +: PW];

  always_comb begin
    rd_word = '0;
    if (rd_port_ok) begin
      case (rd.rd_addr[3:0])
        4'd0:    rd_word = pkt_sh[rd_idx][31:0];
        4'd1:    rd_word = pkt_sh[rd_idx][63:32];
        4'd2:    rd_word = byte_sh[rd_idx][31:0];
        4'd3:    rd_word = byte_sh[rd_idx][63:32];
        4'd4:    rd_word = err_sh[rd_idx];
        4'd5:    rd_word = dpkt_sh[rd_idx][31:0];
        4'd6:    rd_word = dpkt_sh[rd_idx][63:32];
        4'd7:    rd_word = dbyte_sh[rd_idx][31:0];
        4'd8:    rd_word = dbyte_sh[rd_idx][63:32];
        4'd9:    rd_word = {snap_cnt[rd_idx], 14'd0, o_lock_lost[rd_idx], lock_sh[rd_idx]};
        default: rd_word = '0;
      endcase
    end
  end

  // Reads sample the shadows before this edge's capture lands, so they see pre-capture data.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd.rd_vld  <= 1'b0;
      rd.rd_data <= '0;
    end else begin
      rd.rd_vld <= rd.rd_en;
      if (rd.rd_en) begin
        rd.rd_data <= rd_word;
      end
    end
  end

endmodule

// File: tb/tb_dcmac_0_axis_stat_snap.sv
// Self-checking bench for dcmac_0_axis_stat_snap: directed steps plus randomized snapshots
// compared against a per-port behavioural model; honours DCMAC_0_STAT_SNAP_CLEAR_EN.
module tb_dcmac_0_axis_stat_snap;
  localparam int NP = 6;
`ifdef DCMAC_0_STAT_SNAP_CLEAR_EN
  localparam int LAT      = 4;
  localparam int CLR_TICK = 3;
`else
  localparam int LAT      = 3;
  localparam int CLR_TICK = -1;
`endif
  localparam int GAP = LAT;

  logic                clk = 1'b0;
  logic                rst_n;
  logic [NP-1:0][63:0] pkt_cnt;
  logic [NP-1:0][63:0] byte_cnt;
  logic [NP-1:0][31:0] err_cnt;
  logic [NP-1:0]       locked;
  logic [NP-1:0]       snap_req;
  logic [NP-1:0]       clear_counters;
  logic [NP-1:0]       snap_done;
  logic                busy;
  logic [NP-1:0]       lock_lost;

  dcmac_0_axis_stat_snap_if rd_if ();

  dcmac_0_axis_stat_snap #(.NUM_PORTS(NP)) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .i_pkt_cnt        (pkt_cnt),
    .i_byte_cnt       (byte_cnt),
    .i_prbs_err_cnt   (err_cnt),
    .i_prbs_locked    (locked),
    .i_snap_req       (snap_req),
    .o_clear_counters (clear_counters),
    .o_snap_done      (snap_done),
    .o_busy           (busy),
    .o_lock_lost      (lock_lost),
    .rd               (rd_if)
  );

  always #5 clk = ~clk;

  int nVec  = 0;
  int nMiss = 0;

  // Reference model: what each port's register block should hold.
  logic [63:0] mPkt [NP];
  logic [63:0] mByte [NP];
  logic [31:0] mErr [NP];
  logic [63:0] mDpkt [NP];
  logic [63:0] mDbyte [NP];
  logic [63:0] mPrevPkt [NP];
  logic [63:0] mPrevByte [NP];
  logic        mLock [NP];
  int          mCnt [NP];
  logic [NP-1:0] mLost;

  logic [NP-1:0] doneVec [3];
  int            doneAt [3];
  int            nDone;
  int            c;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    nVec++;
    assert (obs === exp) else begin
      nMiss++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic modelReset();
    for (int i = 0; i < NP; i++) begin
      mPkt[i] = '0; mByte[i] = '0; mErr[i] = '0; mDpkt[i] = '0; mDbyte[i] = '0;
      mPrevPkt[i] = '0; mPrevByte[i] = '0; mLock[i] = 1'b0; mCnt[i] = 0;
    end
    mLost = '0;
  endtask

  task automatic modelCapture(input int p, input bit fallAtCapture);
    mDpkt[p]  = pkt_cnt[p] - mPrevPkt[p];
    mDbyte[p] = byte_cnt[p] - mPrevByte[p];
    mPkt[p]   = pkt_cnt[p];
    mByte[p]  = byte_cnt[p];
    mErr[p]   = err_cnt[p];
    mLock[p]  = locked[p];
`ifdef DCMAC_0_STAT_SNAP_CLEAR_EN
    mPrevPkt[p]  = '0;
    mPrevByte[p] = '0;
`else
    mPrevPkt[p]  = pkt_cnt[p];
    mPrevByte[p] = byte_cnt[p];
`endif
    mCnt[p]  = (mCnt[p] + 1) % 65536;
    mLost[p] = fallAtCapture;
  endtask

  task automatic setLocked(input logic [NP-1:0] nv);
    mLost  = mLost | (locked & ~nv);
    locked = nv;
  endtask

  function automatic logic [31:0] expWord(input int p, input int w);
    if (p >= NP) return 32'd0;
    case (w)
      0: return mPkt[p][31:0];
      1: return mPkt[p][63:32];
      2: return mByte[p][31:0];
      3: return mByte[p][63:32];
      4: return mErr[p];
      5: return mDpkt[p][31:0];
      6: return mDpkt[p][63:32];
      7: return mDbyte[p][31:0];
      8: return mDbyte[p][63:32];
      9: return {16'(mCnt[p]), 14'd0, mLost[p], mLock[p]};
      default: return 32'd0;
    endcase
  endfunction

  task automatic readWords(input int p);
    for (int w = 0; w < 16; w++) begin
      rd_if.rd_en   = 1'b1;
      rd_if.rd_addr = 8'(p * 16 + w);
      tick();
      checkOutput("rd_vld", rd_if.rd_vld, 1);
      checkOutput($sformatf("rd_p%0d_w%0d", p, w), rd_if.rd_data, expWord(p, w));
    end
    rd_if.rd_en = 1'b0;
    tick();
    checkOutput("rd_vld_idle", rd_if.rd_vld, 0);
  endtask

  task automatic applyStimulus(input int p, input bit dropLockMid, input bit readMid);
    int            n;
    logic [NP-1:0] oh;
    logic [31:0]   pre;
    oh       = NP'(1) << p;
    pre      = expWord(p, 0);
    snap_req = oh;
    tick();
    snap_req = '0;
    checkOutput("busy_after_req", busy, 1);
    tick();
    n = 2;
    if (dropLockMid) setLocked(locked & ~oh);
    if (readMid) begin
      rd_if.rd_en   = 1'b1;
      rd_if.rd_addr = 8'(p * 16);
    end
    while (snap_done == '0 && n < 20) begin
      tick();
      n++;
      if (readMid && n == 3) begin
        checkOutput("rd_during_capture", rd_if.rd_data, pre);
        rd_if.rd_en = 1'b0;
      end
      checkOutput("clear_counters", clear_counters, (n == CLR_TICK) ? oh : '0);
    end
    checkOutput($sformatf("done_latency_p%0d", p), n, LAT);
    checkOutput("done_vec", snap_done, oh);
    modelCapture(p, dropLockMid);
    checkOutput("lock_lost_after_snap", lock_lost, mLost);
    tick();
    checkOutput("done_pulse_width", snap_done, 0);
    checkOutput("busy_idle", busy, 0);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL global_timeout observed=running expected=finished");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    rst_n = 1'b0;
    pkt_cnt = '0; byte_cnt = '0; err_cnt = '0; locked = '0; snap_req = '0;
    rd_if.rd_en = 1'b0; rd_if.rd_addr = '0;
    modelReset();
    #23;
    checkOutput("rst_busy", busy, 0);
    checkOutput("rst_done", snap_done, 0);
    checkOutput("rst_clear", clear_counters, 0);
    checkOutput("rst_lock_lost", lock_lost, 0);
    checkOutput("rst_rd_vld", rd_if.rd_vld, 0);
    rst_n = 1'b1;
    tick();
    readWords(0);
    readWords(5);

    // Three simultaneous requests right after reset are served 0, 3, 5.
    pkt_cnt[0] = 64'd11; pkt_cnt[3] = 64'd33; pkt_cnt[5] = 64'd55;
    byte_cnt[0] = 64'd1100; byte_cnt[3] = 64'd3300; byte_cnt[5] = 64'd5500;
    for (int i = 0; i < 3; i++) begin doneVec[i] = '0; doneAt[i] = 0; end
    snap_req = 6'b101001;
    tick();
    snap_req = '0;
    nDone = 0;
    c = 1;
    while (nDone < 3 && c < 40) begin
      if (snap_done != '0) begin
        doneVec[nDone] = snap_done;
        doneAt[nDone]  = c;
        nDone++;
      end
      if (nDone < 3) begin
        checkOutput("multi_busy", busy, 1);
        tick();
        c++;
      end
    end
    checkOutput("multi_count", nDone, 3);
    checkOutput("multi_first", doneVec[0], 6'b000001);
    checkOutput("multi_second", doneVec[1], 6'b001000);
    checkOutput("multi_third", doneVec[2], 6'b100000);
    checkOutput("multi_latency", doneAt[0], LAT);
    checkOutput("multi_gap01", doneAt[1] - doneAt[0], GAP);
    checkOutput("multi_gap12", doneAt[2] - doneAt[1], GAP);
    tick();
    checkOutput("multi_busy_low", busy, 0);
    modelCapture(0, 1'b0); modelCapture(3, 1'b0); modelCapture(5, 1'b0);
    readWords(3);

    // Port 2: two snapshots, second one read during its capture cycle.
    pkt_cnt[2] = 64'd100; byte_cnt[2] = 64'd6400; err_cnt[2] = 32'd7;
    applyStimulus(2, 1'b0, 1'b0);
    pkt_cnt[2] = 64'd150; byte_cnt[2] = 64'd9600; err_cnt[2] = 32'd9;
    applyStimulus(2, 1'b0, 1'b1);
    readWords(2);

    // 64-bit wrap of the delta.
    pkt_cnt[2] = 64'hFFFF_FFFF_FFFF_FFF0; byte_cnt[2] = 64'hFFFF_FFFF_FFFF_FF00;
    applyStimulus(2, 1'b0, 1'b0);
    pkt_cnt[2] = 64'h10; byte_cnt[2] = 64'h40;
    applyStimulus(2, 1'b0, 1'b0);
    readWords(2);

    pkt_cnt[4] = 64'd400; byte_cnt[4] = 64'd40000;
    applyStimulus(4, 1'b0, 1'b0);
    pkt_cnt[4] = 64'd420; byte_cnt[4] = 64'd41000;
    applyStimulus(4, 1'b0, 1'b0);
    readWords(4);

    // Lock loss on port 1: set, cleared by snapshot, then kept by a coincident edge.
    setLocked(locked | 6'b000010);
    tick(); tick();
    setLocked(locked & ~6'b000010);
    tick();
    checkOutput("lock_lost_set", lock_lost, mLost);
    applyStimulus(1, 1'b0, 1'b0);
    setLocked(locked | 6'b000010);
    tick();
    applyStimulus(1, 1'b1, 1'b0);
    readWords(1);

    for (int it = 0; it < 20; it++) begin
      int p;
      p = int'($urandom_range(0, NP - 1));
      for (int i = 0; i < NP; i++) begin
        pkt_cnt[i]  = {$urandom, $urandom};
        byte_cnt[i] = {$urandom, $urandom};
        err_cnt[i]  = $urandom;
      end
      setLocked(NP'($urandom));
      tick();
      checkOutput("rand_lock_lost", lock_lost, mLost);
      applyStimulus(p, 1'b0, 1'b0);
      readWords(p);
    end
    readWords(6 + int'($urandom_range(0, 9)));

    // Asynchronous reset in the middle of a snapshot.
    pkt_cnt[4] = 64'd777;
    snap_req = 6'b010000;
    tick();
    snap_req = '0;
    tick();
`ifdef DCMAC_0_STAT_SNAP_CLEAR_EN
    tick();
    checkOutput("clear_pre_reset", clear_counters, 6'b010000);
`endif
    #1 rst_n = 1'b0;
    #1;
    checkOutput("midrst_clear", clear_counters, 0);
    checkOutput("midrst_busy", busy, 0);
    checkOutput("midrst_done", snap_done, 0);
    checkOutput("midrst_lock_lost", lock_lost, 0);
    modelReset();
    #3 rst_n = 1'b1;
    tick();
    checkOutput("postrst_busy", busy, 0);
    readWords(4);
    readWords(0);

    $display("== %0d vectors applied, %0d miscompares ==", nVec, nMiss);
    $finish;
  end
endmodule
